spill_buffer_flushable: RTL and testbench

//   Parametrised-depth successor to the two-entry flushable spill register: a valid/ready

---
 rtl/spill_buffer_flushable_pkg.sv | 6 +
 rtl/spill_buffer_flushable.sv | 78 +++++++
 tb/tb_spill_buffer_flushable.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spill_buffer_flushable_pkg.sv
// spill_buffer_flushable_pkg: index-width helper shared by the spill buffer.
package spill_buffer_flushable_pkg;
   function automatic integer idx_width(input integer n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/spill_buffer_flushable.sv
// spill_buffer_flushable: Depth-entry valid/ready buffer with registered outputs, flush, clear and usage.
module spill_buffer_flushable
   import spill_buffer_flushable_pkg::*;
#(
   parameter type         T      = logic,
   parameter int unsigned Depth  = 2,
   parameter bit          Bypass = 1'b0
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic                       clr_i,
   input  logic                       flush_i,
   input  logic                       valid_i,
   output logic                       ready_o,
   input  T                           data_i,
   output logic                       valid_o,
   input  logic                       ready_i,
   output T                           data_o,
   output logic [$clog2(Depth+1)-1:0] usage_o
);
   if (Depth < 2) begin : g_bad_depth
      $fatal(1, "spill_buffer_flushable: Depth must be >= 2");
   end
   if (Bypass) begin : g_bypass
      logic unused_bypass;
      assign unused_bypass = ^{clk_i, rst_ni, clr_i, flush_i};
      assign valid_o = valid_i;
      assign ready_o = ready_i;
      assign data_o  = data_i;
      assign usage_o = '0;
   end else begin : g_buf
      localparam int unsigned PtrW = idx_width(Depth);
      localparam int unsigned CntW = $clog2(Depth + 1);
      T                mem [Depth];
      logic [PtrW-1:0] rd_ptr, wr_ptr;
      logic [CntW-1:0] count;
      logic            push, pop;
      function automatic logic [PtrW-1:0] nxt(input logic [PtrW-1:0] p);
         return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
      endfunction
      assign ready_o = count != CntW'(Depth);
      assign valid_o = count != '0;
      assign data_o  = mem[rd_ptr];
      assign usage_o = count;
      // A flush voids both handshakes of its cycle.
      assign push = valid_i & ready_o & ~flush_i;
      assign pop  = valid_o & ready_i & ~flush_i;
      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
         end else if (clr_i) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
         end else if (flush_i) begin
            count  <= '0;
            rd_ptr <= wr_ptr;
         end else begin
            if (push) wr_ptr <= nxt(wr_ptr);
            if (pop) rd_ptr <= nxt(rd_ptr);
            count <= count + CntW'(push) - CntW'(pop);
         end
      end
      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            for (int i = 0; i < int'(Depth); i++) mem[i] <= '0;
         end else if (clr_i) begin
            for (int i = 0; i < int'(Depth); i++) mem[i] <= '0;
         end else if (push) begin
            mem[wr_ptr] <= data_i;
         end
      end
      a_flush_no_valid: assert property (@(posedge clk_i) disable iff (!rst_ni) flush_i |-> !valid_i)
         else $warning("spill_buffer_flushable: upstream beat discarded by flush");
   end
endmodule

// File: tb/tb_spill_buffer_flushable.sv
// tb_spill_buffer_flushable: directed and randomized checks of the spill buffer against a queue model.
module tb_spill_buffer_flushable;
   localparam int NB = 4;
   localparam int DEP [NB] = '{4, 3, 2, 8};
   logic       clk, rst_n;
   logic       vld [5], rdy [5], fl [5], cl [5], vo [5], ro [5];
   logic [7:0] din [5], dout [5];
   logic [2:0] us0;
   logic [1:0] us1, us2, us4;
   logic [3:0] us3;
   logic [7:0] q [NB][$];
   int         checks = 0, failures = 0;

   spill_buffer_flushable #(.T(logic [7:0]), .Depth(4)) d0 (.clk_i(clk), .rst_ni(rst_n), .clr_i(cl[0]),
      .flush_i(fl[0]), .valid_i(vld[0]), .ready_o(ro[0]), .data_i(din[0]), .valid_o(vo[0]),
      .ready_i(rdy[0]), .data_o(dout[0]), .usage_o(us0));
   spill_buffer_flushable #(.T(logic [7:0]), .Depth(3)) d1 (.clk_i(clk), .rst_ni(rst_n), .clr_i(cl[1]),
      .flush_i(fl[1]), .valid_i(vld[1]), .ready_o(ro[1]), .data_i(din[1]), .valid_o(vo[1]),
      .ready_i(rdy[1]), .data_o(dout[1]), .usage_o(us1));
   spill_buffer_flushable #(.T(logic [7:0]), .Depth(2)) d2 (.clk_i(clk), .rst_ni(rst_n), .clr_i(cl[2]),
      .flush_i(fl[2]), .valid_i(vld[2]), .ready_o(ro[2]), .data_i(din[2]), .valid_o(vo[2]),
      .ready_i(rdy[2]), .data_o(dout[2]), .usage_o(us2));
   spill_buffer_flushable #(.T(logic [7:0]), .Depth(8)) d3 (.clk_i(clk), .rst_ni(rst_n), .clr_i(cl[3]),
      .flush_i(fl[3]), .valid_i(vld[3]), .ready_o(ro[3]), .data_i(din[3]), .valid_o(vo[3]),
      .ready_i(rdy[3]), .data_o(dout[3]), .usage_o(us3));
   spill_buffer_flushable #(.T(logic [7:0]), .Depth(2), .Bypass(1'b1)) d4 (.clk_i(clk), .rst_ni(rst_n),
      .clr_i(cl[4]), .flush_i(fl[4]), .valid_i(vld[4]), .ready_o(ro[4]), .data_i(din[4]),
      .valid_o(vo[4]), .ready_i(rdy[4]), .data_o(dout[4]), .usage_o(us4));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int usage_of(input int k);
      case (k)
         0: return int'(us0);
         1: return int'(us1);
         2: return int'(us2);
         3: return int'(us3);
         default: return int'(us4);
      endcase
   endfunction

   task automatic idle_all();
      for (int k = 0; k < 5; k++) begin
         vld[k] = 1'b0; rdy[k] = 1'b0; fl[k] = 1'b0; cl[k] = 1'b0; din[k] = 8'h00;
      end
   endtask

   // Reference: the buffer is a bounded FIFO; an accepted beat appears at its tail after the edge.
   task automatic tick();
      bit pu, po;
      @(posedge clk);
      for (int k = 0; k < NB; k++) begin
         if (!rst_n || cl[k] || fl[k]) q[k].delete();
         else begin
            pu = vld[k] && q[k].size() != DEP[k];
            po = rdy[k] && q[k].size() != 0;
            if (po) void'(q[k].pop_front());
            if (pu) q[k].push_back(din[k]);
         end
      end
      #1;
   endtask

   task automatic test_reset();
      idle_all();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      for (int k = 0; k < NB; k++) begin
         checks++;
         if (vo[k] !== 1'b0 || ro[k] !== 1'b1 || usage_of(k) != 0 || dout[k] !== 8'h00) begin
            failures++;
            $display("FAIL reset k=%0d got valid=%b ready=%b usage=%0d data=%h want 0 1 0 00",
                     k, vo[k], ro[k], usage_of(k), dout[k]);
         end
      end
      vld[4] = 1'b1; rdy[4] = 1'b0; din[4] = 8'h5A;
      #1;
      checks++;
      if (vo[4] !== 1'b1 || ro[4] !== 1'b0 || dout[4] !== 8'h5A || usage_of(4) != 0) begin
         failures++;
         $display("FAIL bypass_static got valid=%b ready=%b data=%h usage=%0d want 1 0 5a 0",
                  vo[4], ro[4], dout[4], usage_of(4));
      end
      idle_all();
   endtask

   task automatic test_fill_drain();
      logic [7:0] exp [4] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
      rdy[0] = 1'b0;
      for (int i = 0; i < 4; i++) begin
         vld[0] = 1'b1; din[0] = exp[i];
         tick();
      end
      vld[0] = 1'b0;
      checks++;
      if (ro[0] !== 1'b0 || usage_of(0) != 4 || vo[0] !== 1'b1) begin
         failures++;
         $display("FAIL fill_full got ready=%b usage=%0d valid=%b want 0 4 1", ro[0], usage_of(0), vo[0]);
      end
      rdy[0] = 1'b1;
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (vo[0] !== 1'b1 || dout[0] !== exp[i]) begin
            failures++;
            $display("FAIL drain_order i=%0d got valid=%b data=%h want 1 %h", i, vo[0], dout[0], exp[i]);
         end
         tick();
      end
      checks++;
      if (vo[0] !== 1'b0 || usage_of(0) != 0) begin
         failures++;
         $display("FAIL drain_empty got valid=%b usage=%0d want 0 0", vo[0], usage_of(0));
      end
      idle_all();
   endtask

   task automatic test_stream_wrap();
      rdy[1] = 1'b1;
      for (int i = 0; i < 10; i++) begin
         vld[1] = 1'b1; din[1] = 8'h30 + 8'(i);
         tick();
         checks++;
         if (vo[1] !== 1'b1 || dout[1] !== 8'h30 + 8'(i) || usage_of(1) != 1) begin
            failures++;
            $display("FAIL stream i=%0d got valid=%b data=%h usage=%0d want 1 %h 1",
                     i, vo[1], dout[1], usage_of(1), 8'h30 + 8'(i));
         end
      end
      vld[1] = 1'b0;
      tick();
      checks++;
      if (vo[1] !== 1'b0 || usage_of(1) != 0) begin
         failures++;
         $display("FAIL stream_end got valid=%b usage=%0d want 0 0", vo[1], usage_of(1));
      end
      idle_all();
   endtask

   task automatic test_full_pop();
      logic [7:0] exp [4] = '{8'h41, 8'h42, 8'h43, 8'h44};
      for (int i = 0; i < 4; i++) begin
         vld[0] = 1'b1; din[0] = 8'h40 + 8'(i);
         tick();
      end
      din[0] = 8'h44; rdy[0] = 1'b1;
      checks++;
      if (ro[0] !== 1'b0) begin
         failures++;
         $display("FAIL full_pop_block got ready=%b want 0", ro[0]);
      end
      tick();
      checks++;
      if (ro[0] !== 1'b1 || usage_of(0) != 3 || dout[0] !== exp[0]) begin
         failures++;
         $display("FAIL full_pop_free got ready=%b usage=%0d data=%h want 1 3 41", ro[0], usage_of(0), dout[0]);
      end
      tick();
      vld[0] = 1'b0;
      for (int i = 1; i < 4; i++) begin
         checks++;
         if (vo[0] !== 1'b1 || dout[0] !== exp[i]) begin
            failures++;
            $display("FAIL full_pop_order i=%0d got valid=%b data=%h want 1 %h", i, vo[0], dout[0], exp[i]);
         end
         tick();
      end
      checks++;
      if (vo[0] !== 1'b0) begin
         failures++;
         $display("FAIL full_pop_dup got valid=%b want 0", vo[0]);
      end
      idle_all();
   endtask

   task automatic test_flush();
      for (int i = 0; i < 3; i++) begin
         vld[0] = 1'b1; din[0] = 8'h50 + 8'(i);
         tick();
      end
      vld[0] = 1'b0;
      checks++;
      if (usage_of(0) != 3) begin
         failures++;
         $display("FAIL flush_pre got usage=%0d want 3", usage_of(0));
      end
      fl[0] = 1'b1;
      tick();
      fl[0] = 1'b0;
      checks++;
      if (vo[0] !== 1'b0 || usage_of(0) != 0 || ro[0] !== 1'b1) begin
         failures++;
         $display("FAIL flush got valid=%b usage=%0d ready=%b want 0 0 1", vo[0], usage_of(0), ro[0]);
      end
      vld[0] = 1'b1; din[0] = 8'hEE;
      tick();
      vld[0] = 1'b0;
      checks++;
      if (vo[0] !== 1'b1 || dout[0] !== 8'hEE || usage_of(0) != 1) begin
         failures++;
         $display("FAIL flush_next got valid=%b data=%h usage=%0d want 1 ee 1", vo[0], dout[0], usage_of(0));
      end
      rdy[0] = 1'b1;
      tick();
      checks++;
      if (vo[0] !== 1'b0) begin
         failures++;
         $display("FAIL flush_drain got valid=%b want 0", vo[0]);
      end
      idle_all();
   endtask

   task automatic test_clear();
      for (int i = 0; i < 2; i++) begin
         vld[1] = 1'b1; din[1] = 8'h60 + 8'(i);
         tick();
      end
      vld[1] = 1'b0;
      checks++;
      if (usage_of(1) != 2) begin
         failures++;
         $display("FAIL clr_pre got usage=%0d want 2", usage_of(1));
      end
      cl[1] = 1'b1; fl[1] = 1'b1;
      tick();
      cl[1] = 1'b0; fl[1] = 1'b0;
      checks++;
      if (vo[1] !== 1'b0 || usage_of(1) != 0 || dout[1] !== 8'h00 || ro[1] !== 1'b1) begin
         failures++;
         $display("FAIL clr got valid=%b usage=%0d data=%h ready=%b want 0 0 00 1",
                  vo[1], usage_of(1), dout[1], ro[1]);
      end
      idle_all();
   endtask

   task automatic test_async_reset();
      vld[2] = 1'b1; din[2] = 8'h77;
      tick();
      vld[2] = 1'b1; din[2] = 8'h78;
      tick();
      vld[2] = 1'b0;
      checks++;
      if (usage_of(2) != 2 || vo[2] !== 1'b1) begin
         failures++;
         $display("FAIL arst_pre got usage=%0d valid=%b want 2 1", usage_of(2), vo[2]);
      end
      #2 rst_n = 1'b0;
      for (int k = 0; k < NB; k++) q[k].delete();
      #1;
      checks++;
      if (vo[2] !== 1'b0 || ro[2] !== 1'b1 || usage_of(2) != 0 || dout[2] !== 8'h00) begin
         failures++;
         $display("FAIL arst got valid=%b ready=%b usage=%0d data=%h want 0 1 0 00",
                  vo[2], ro[2], usage_of(2), dout[2]);
      end
      tick();
      rst_n = 1'b1;
      idle_all();
   endtask

   task automatic test_random();
      for (int c = 0; c < 10000; c++) begin
         for (int k = 0; k < 5; k++) begin
            vld[k] = 1'($urandom_range(0, 3) != 0);
            rdy[k] = 1'($urandom_range(0, 2) != 0);
            din[k] = 8'($urandom);
            fl[k]  = 1'($urandom_range(0, 47) == 0);
            cl[k]  = 1'($urandom_range(0, 95) == 0);
         end
         #1;
         checks++;
         if (vo[4] !== vld[4] || ro[4] !== rdy[4] || dout[4] !== din[4] || usage_of(4) != 0) begin
            failures++;
            $display("FAIL rand_bypass c=%0d got %b %b %h %0d want %b %b %h 0",
                     c, vo[4], ro[4], dout[4], usage_of(4), vld[4], rdy[4], din[4]);
         end
         tick();
         for (int k = 0; k < NB; k++) begin
            checks++;
            if (vo[k] !== (q[k].size() != 0) || ro[k] !== (q[k].size() != DEP[k]) ||
                usage_of(k) != q[k].size() || (q[k].size() != 0 && dout[k] !== q[k][0])) begin
               failures++;
               $display("FAIL rand k=%0d c=%0d got valid=%b ready=%b usage=%0d data=%h want usage=%0d head=%h",
                        k, c, vo[k], ro[k], usage_of(k), dout[k], q[k].size(),
                        q[k].size() != 0 ? q[k][0] : 8'h00);
            end
         end
      end
      idle_all();
   endtask

   initial begin
      test_reset();
      test_fill_drain();
      test_stream_wrap();
      test_full_pop();
      test_flush();
      test_clear();
      test_async_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
